// File: rtl/skid_regslice_2e.sv
// Two-entry skid buffer register slice: every output comes straight from a flop.
// Optional saturating stall/full counters are enabled with `define SKID_PERF_CNT_EN.
module skid_regslice_2e #(
   parameter int WIDTH = 32
`ifdef SKID_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_payload,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_payload
`ifdef SKID_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] full_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   main_reg, main_next;
   logic [WIDTH-1:0]   skid_reg, skid_next;
   logic               pop_valid_reg;
   logic               push_ready_reg;
   logic               push_fire;
   logic               pop_fire;

   assign push_fire = push_valid & push_ready_reg;
   assign pop_fire  = pop_valid_reg & pop_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (push_fire) begin
               state_next = BUSY;
               main_next  = push_payload;
            end
         end
         BUSY: begin
            if (push_fire && pop_fire) begin
               main_next = push_payload;
            end else if (push_fire) begin
               state_next = FULL;
               skid_next  = push_payload;
            end else if (pop_fire) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            // push_ready is low here, so only the drain path exists
            if (pop_fire) begin
               state_next = BUSY;
               main_next  = skid_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // Flags are registered from the next state so push_ready stays low
   // through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= EMPTY;
         main_reg       <= '0;
         skid_reg       <= '0;
         pop_valid_reg  <= 1'b0;
         push_ready_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         main_reg       <= main_next;
         skid_reg       <= skid_next;
         pop_valid_reg  <= (state_next != EMPTY);
         push_ready_reg <= (state_next != FULL);
      end
   end

   assign pop_valid   = pop_valid_reg;
   assign push_ready  = push_ready_reg;
   assign pop_payload = main_reg;

`ifdef SKID_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] full_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
         full_cnt_reg  <= '0;
      end else begin
         if (pop_valid_reg && !pop_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if ((state_reg == FULL) && (full_cnt_reg != {CNT_W{1'b1}}))
            full_cnt_reg <= full_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign full_cnt  = full_cnt_reg;
`endif

endmodule

// File: doc/skid_regslice_2e.md
Name: skid_regslice_2e

Overview:
- Full-throughput valid/ready register slice built as a two-entry skid buffer, placed between a push-side producer and a pop-side consumer.
- Breaks every combinational path between the two sides: pop_valid, pop_payload and push_ready are all driven from flops.
- Sustains one transfer per cycle under continuous flow; holds up to two beats under backpressure.
- This is the synthesizable far end of the push/pop handshake that our send_data/recv_data VIP tasks drive and sample.

Parameters:
- WIDTH, 32, payload width in bits.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  upstream beat valid.
- push_ready  out  1  slice can accept a beat; registered.
- push_payload  in  WIDTH  upstream data.
- pop_valid  out  1  downstream beat valid; registered.
- pop_ready  in  1  downstream accepts.
- pop_payload  out  WIDTH  downstream data; registered.
- stall_cnt  out  CNT_W  cycles with pop_valid=1 and pop_ready=0 (SKID_PERF_CNT_EN only).
- full_cnt  out  CNT_W  cycles spent in FULL (SKID_PERF_CNT_EN only).

Behaviour:
- Definitions: push_fire = push_valid & push_ready; pop_fire = pop_valid & pop_ready.
- Storage: main register drives pop_payload; skid register holds the second beat.
- States:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: both valid.
- Outputs by state: pop_valid = (state != EMPTY); push_ready = (state != FULL). Both are held in flops, never decoded from inputs.
- Transitions:
  - EMPTY + push_fire -> BUSY; main <= push_payload.
  - BUSY + push_fire + pop_fire -> BUSY; main <= push_payload.
  - BUSY + push_fire + !pop_fire -> FULL; skid <= push_payload.
  - BUSY + !push_fire + pop_fire -> EMPTY.
  - FULL + pop_fire -> BUSY; main <= skid. No push is possible in FULL because push_ready=0.
  - All other cases: hold state and data.
- Latency: a beat accepted at edge N is visible on pop_valid/pop_payload after edge N; one cycle.
- Throughput: 1 beat/cycle when pop_ready is held high.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stability: while pop_valid=1 and pop_ready=0, pop_payload is held constant. push_payload is sampled only on push_fire.
- Upstream may deassert push_valid at any time, including after a non-accepted cycle. Downstream may toggle pop_ready freely.
- Reset (rst_n=0, asynchronous, any state including FULL):
  - state -> EMPTY; pop_valid=0; push_ready=0; pop_payload=0; skid=0.
  - In-flight beats are discarded.
  - push_ready rises on the first rising edge after rst_n deasserts, so no beat is accepted during or at reset release.
- Simultaneous push_fire and pop_fire in BUSY: the new beat replaces main; occupancy unchanged.

Optional Feature:
- Macro: SKID_PERF_CNT_EN.
- Defined:
  - stall_cnt and full_cnt ports exist.
  - Both counters are saturating (stick at all-ones, no wrap) and reset to 0 by rst_n.
  - stall_cnt increments each cycle with pop_valid & !pop_ready.
  - full_cnt increments each cycle with state==FULL.
- Undefined: the ports and counters are absent; datapath behaviour is identical.

Test Plan:
- Single beat:
  - Stimulus: rst release, then send 0xA5A5_0001 with pop_ready=1.
  - Response: push_ready=1 one cycle after release; pop_valid=1 with 0xA5A5_0001 exactly one cycle after acceptance; back to EMPTY next cycle.
- Streaming:
  - Stimulus: pop_ready=1, push 0x1..0x10 on 16 consecutive cycles.
  - Response: push_ready never drops; 0x1..0x10 pop in order on 16 consecutive cycles, starting one cycle after the first push.
- Backpressure:
  - Stimulus: pop_ready=0, push 0xA, 0xB, 0xC.
  - Response: 0xA and 0xB accepted; push_ready=0 after the second accept; 0xC held upstream; pop_payload stays 0xA.
  - Stimulus: release pop_ready.
  - Response: pop order 0xA, 0xB, 0xC.
- Gapped VIP traffic:
  - Stimulus: send_data gap=2, recv_data gap=3, 50 random payloads.
  - Response: scoreboard exact match; no pop_payload change while pop_valid & !pop_ready.
- Reset mid-operation:
  - Stimulus: reach FULL with 0x11, 0x22; assert rst_n=0 between edges.
  - Response: pop_valid=0 and push_ready=0 immediately; after release no stale 0x11/0x22 popped; next push 0x33 is the first beat out.
- Counters (SKID_PERF_CNT_EN):
  - Stimulus: hold FULL with pop_ready=0 for 10 cycles.
  - Response: full_cnt=10 and stall_cnt≥10.
  - Stimulus: force CNT_W=4 and stall 20 cycles.
  - Response: stall_cnt saturates at 15.
